// File: rtl/fft_bitrev_reorder.sv
// Bit-reversal reorder buffer behind the R2SDF FFT core: captures bit-reversed frames into
// ping-pong banks and replays them in natural order over a valid/ready stream.
module fft_bitrev_reorder #(
  parameter int N = 3,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_start,
  input  logic [W-1:0] in_re,
  input  logic [W-1:0] in_im,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_re,
  output logic [W-1:0] out_im,
  output logic [N-1:0] out_idx,
  output logic         out_last,
  output logic         overflow
);

  localparam int DEPTH = 1 << N;
  localparam logic [N-1:0] LAST = '1;
  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {W_IDLE, W_FILL}  wstate_t;
  typedef enum logic {R_IDLE, R_DRAIN} rstate_t;

  function automatic logic [N-1:0] bitrev(input logic [N-1:0] a);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = a[N-1-i];
    return r;
  endfunction

  // Stage p0: incoming raw sample and write side
  logic signed [W-1:0] w_in_re_p0, w_in_im_p0;
  assign w_in_re_p0 = in_re;
  assign w_in_im_p0 = in_im;

  wstate_t      r_wstate, w_wstate_nxt;
  logic [N-1:0] r_wcnt, w_wcnt_nxt;
  logic         r_wbank, w_wbank_nxt;
  logic         w_wr_en, w_done, w_ovf, w_free;
  logic [N-1:0] w_waddr;
  logic [1:0]   r_full, w_full_nxt;
  logic         r_ovf;

  rstate_t      r_rstate, w_rstate_nxt;
  logic         r_rbank;
  logic [N-1:0] r_ra;
  logic         w_rd_en, w_rel, w_room, w_other;

  logic signed [W-1:0] r_mem_re [2][DEPTH];
  logic signed [W-1:0] r_mem_im [2][DEPTH];

  // Stage p1: synchronous RAM read register
  logic                r_rd_vld_p1;
  logic signed [W-1:0] r_rd_re_p1, r_rd_im_p1;
  logic [N-1:0]        r_rd_idx_p1;

  // Stage p2: two-entry skid, entry 0 is the head
  logic [1:0]          r_sk_cnt_p2;
  logic signed [W-1:0] r_sk_re_p2 [2];
  logic signed [W-1:0] r_sk_im_p2 [2];
  logic [N-1:0]        r_sk_idx_p2 [2];
  logic                w_pop, w_push, w_slot, w_o_load;

  // Stage p3: registered stream output
  logic                r_out_vld_p3, r_out_last_p3;
  logic signed [W-1:0] r_out_re_p3, r_out_im_p3;
  logic [N-1:0]        r_out_idx_p3;

  // A read is only issued when its data is guaranteed a slot two cycles later.
  assign w_room  = ({1'b0, r_sk_cnt_p2} + {2'b00, r_rd_vld_p1}) < 3'd2;
  assign w_rd_en = r_full[r_rbank] && w_room;
  assign w_rel   = w_rd_en && (r_ra == LAST);
  assign w_other = ~r_rbank;
  assign w_free  = !r_full[r_wbank] || (w_rel && (r_rbank == r_wbank));

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wcnt_nxt   = r_wcnt;
    w_wbank_nxt  = r_wbank;
    w_wr_en      = 1'b0;
    w_waddr      = '0;
    w_done       = 1'b0;
    w_ovf        = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (in_start) begin
          if (w_free) begin
            w_wr_en      = 1'b1;
            w_wcnt_nxt   = ONE;
            w_wstate_nxt = W_FILL;
          end else begin
            w_ovf = 1'b1;
          end
        end
      end
      W_FILL: begin
        w_wr_en = 1'b1;
        if (in_start) begin
          w_wcnt_nxt = ONE;
        end else begin
          w_waddr    = bitrev(r_wcnt);
          w_wcnt_nxt = r_wcnt + ONE;
          if (r_wcnt == LAST) begin
            w_done       = 1'b1;
            w_wbank_nxt  = ~r_wbank;
            w_wstate_nxt = W_IDLE;
          end
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_rd_en) w_rstate_nxt = R_DRAIN;
      R_DRAIN: if (w_rel && !r_full[w_other]) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_full_nxt = r_full;
    if (w_rel)  w_full_nxt[r_rbank] = 1'b0;
    if (w_done) w_full_nxt[r_wbank] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate <= W_IDLE;
      r_wcnt   <= '0;
      r_wbank  <= 1'b0;
      r_full   <= '0;
      r_ovf    <= 1'b0;
      r_rstate <= R_IDLE;
      r_rbank  <= 1'b0;
      r_ra     <= '0;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_wcnt   <= w_wcnt_nxt;
      r_wbank  <= w_wbank_nxt;
      r_full   <= w_full_nxt;
      r_ovf    <= w_ovf;
      r_rstate <= w_rstate_nxt;
      if (w_rd_en) r_ra <= r_ra + ONE;
      if (w_rel)   r_rbank <= w_other;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem_re[r_wbank][w_waddr] <= w_in_re_p0;
      r_mem_im[r_wbank][w_waddr] <= w_in_im_p0;
    end
    if (w_rd_en) begin
      r_rd_re_p1  <= r_mem_re[r_rbank][r_ra];
      r_rd_im_p1  <= r_mem_im[r_rbank][r_ra];
      r_rd_idx_p1 <= r_ra;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rd_vld_p1 <= 1'b0;
    else     r_rd_vld_p1 <= w_rd_en;
  end

  // Output slot refills from the skid head first, else straight from the RAM register.
  assign w_o_load = !r_out_vld_p3 || out_ready;
  assign w_pop    = w_o_load && (r_sk_cnt_p2 != 2'd0);
  assign w_push   = r_rd_vld_p1 && !(w_o_load && (r_sk_cnt_p2 == 2'd0));
  assign w_slot   = r_sk_cnt_p2[0] & ~w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sk_cnt_p2 <= 2'd0;
    else     r_sk_cnt_p2 <= r_sk_cnt_p2 + {1'b0, w_push} - {1'b0, w_pop};
  end

  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_sk_re_p2[0]  <= r_sk_re_p2[1];
      r_sk_im_p2[0]  <= r_sk_im_p2[1];
      r_sk_idx_p2[0] <= r_sk_idx_p2[1];
    end
    if (w_push) begin
      r_sk_re_p2[w_slot]  <= r_rd_re_p1;
      r_sk_im_p2[w_slot]  <= r_rd_im_p1;
      r_sk_idx_p2[w_slot] <= r_rd_idx_p1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_vld_p3  <= 1'b0;
      r_out_last_p3 <= 1'b0;
      r_out_re_p3   <= '0;
      r_out_im_p3   <= '0;
      r_out_idx_p3  <= '0;
    end else if (w_o_load) begin
      r_out_vld_p3 <= (r_sk_cnt_p2 != 2'd0) || r_rd_vld_p1;
      if (r_sk_cnt_p2 != 2'd0) begin
        r_out_re_p3   <= r_sk_re_p2[0];
        r_out_im_p3   <= r_sk_im_p2[0];
        r_out_idx_p3  <= r_sk_idx_p2[0];
        r_out_last_p3 <= (r_sk_idx_p2[0] == LAST);
      end else if (r_rd_vld_p1) begin
        r_out_re_p3   <= r_rd_re_p1;
        r_out_im_p3   <= r_rd_im_p1;
        r_out_idx_p3  <= r_rd_idx_p1;
        r_out_last_p3 <= (r_rd_idx_p1 == LAST);
      end else begin
        r_out_last_p3 <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_vld_p3;
  assign out_re    = r_out_re_p3;
  assign out_im    = r_out_im_p3;
  assign out_idx   = r_out_idx_p3;
  assign out_last  = r_out_last_p3;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder with N=3: ordering, latency, streaming,
// backpressure, overflow, abort and mid-drain reset.
module tb_fft_bitrev_reorder;
  localparam int N = 3;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_start = 1'b0;
  logic [W-1:0] in_re = '0;
  logic [W-1:0] in_im = '0;
  logic         out_ready = 1'b0;
  logic         out_valid, out_last, overflow;
  logic [W-1:0] out_re, out_im;
  logic [N-1:0] out_idx;

  fft_bitrev_reorder #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_start(in_start), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_idx(out_idx), .out_last(out_last), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ovf_cnt = 0;
  logic [W-1:0] q_re[$];
  logic [W-1:0] q_im[$];
  logic [N-1:0] q_idx[$];
  logic         q_last[$];
  int           q_cyc[$];
  int BR[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        q_re.push_back(out_re);
        q_im.push_back(out_im);
        q_idx.push_back(out_idx);
        q_last.push_back(out_last);
        q_cyc.push_back(cyc);
      end
      if (overflow) ovf_cnt <= ovf_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int base, input int nsamp, output int last_cyc);
    for (int p = 0; p < nsamp; p++) begin
      in_start = (p == 0);
      in_re = W'(base + p);
      in_im = W'(-(base + p));
      tick();
    end
    in_start = 1'b0;
    last_cyc = cyc;
  endtask

  task automatic wait_outputs(input int target, input int budget);
    for (int i = 0; i < budget && q_re.size() < target; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_re !== '0) begin errors++; $display("FAIL reset_re: got %h want 0", out_re); end
    checks++; if (out_im !== '0) begin errors++; $display("FAIL reset_im: got %h want 0", out_im); end
    checks++; if (out_idx !== '0) begin errors++; $display("FAIL reset_idx: got %0d want 0", out_idx); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", out_last); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_frame();
    int qb, ob, ce;
    out_ready = 1'b1;
    qb = q_re.size();
    ob = ovf_cnt;
    send_frame(0, 8, ce);
    wait_outputs(qb + 8, 40);
    tick();
    checks++; if (q_re.size() !== qb + 8) begin errors++; $display("FAIL single_count: got %0d want %0d", q_re.size() - qb, 8); end
    for (int k = 0; k < 8 && qb + k < q_re.size(); k++) begin
      logic [W-1:0] er, ei;
      logic [N-1:0] ex;
      er = W'(BR[k]);
      ei = W'(-BR[k]);
      ex = N'(k);
      checks++;
      if ({q_re[qb+k], q_im[qb+k], q_idx[qb+k], q_last[qb+k]} !== {er, ei, ex, (k == 7)}) begin
        errors++;
        $display("FAIL single_data[%0d]: got re=%h im=%h idx=%0d last=%b want re=%h im=%h idx=%0d last=%b",
                 k, q_re[qb+k], q_im[qb+k], q_idx[qb+k], q_last[qb+k], er, ei, ex, (k == 7));
      end
      checks++;
      if (q_cyc[qb+k] !== ce + 2 + k) begin
        errors++;
        $display("FAIL single_timing[%0d]: got cycle %0d want %0d", k, q_cyc[qb+k], ce + 2 + k);
      end
    end
    checks++; if (ovf_cnt !== ob) begin errors++; $display("FAIL single_overflow: got %0d pulses want 0", ovf_cnt - ob); end
  endtask

  task automatic test_back_to_back();
    int qb, ob, ce;
    out_ready = 1'b1;
    qb = q_re.size();
    ob = ovf_cnt;
    for (int f = 0; f < 8; f++) send_frame(16 * f, 8, ce);
    wait_outputs(qb + 64, 200);
    tick();
    checks++; if (q_re.size() !== qb + 64) begin errors++; $display("FAIL b2b_count: got %0d want 64", q_re.size() - qb); end
    for (int j = 0; j < 64 && qb + j < q_re.size(); j++) begin
      logic [W-1:0] er, ei;
      logic [N-1:0] ex;
      er = W'(16 * (j / 8) + BR[j % 8]);
      ei = W'(-(16 * (j / 8) + BR[j % 8]));
      ex = N'(j % 8);
      checks++;
      if ({q_re[qb+j], q_im[qb+j], q_idx[qb+j], q_last[qb+j]} !== {er, ei, ex, (j % 8 == 7)}) begin
        errors++;
        $display("FAIL b2b_data[%0d]: got re=%h im=%h idx=%0d last=%b want re=%h im=%h idx=%0d",
                 j, q_re[qb+j], q_im[qb+j], q_idx[qb+j], q_last[qb+j], er, ei, ex);
      end
      if (j > 0) begin
        checks++;
        if (q_cyc[qb+j] !== q_cyc[qb] + j) begin
          errors++;
          $display("FAIL b2b_bubble[%0d]: got cycle %0d want %0d", j, q_cyc[qb+j], q_cyc[qb] + j);
        end
      end
    end
    checks++; if (ovf_cnt !== ob) begin errors++; $display("FAIL b2b_overflow: got %0d pulses want 0", ovf_cnt - ob); end
  endtask

  task automatic test_backpressure();
    int qb, ob;
    logic pv;
    logic [W-1:0] pre, pim;
    logic [N-1:0] pidx;
    logic rdy;
    qb = q_re.size();
    ob = ovf_cnt;
    for (int i = 0; i < 200; i++) begin
      if (i >= 16 && q_re.size() >= qb + 16) break;
      rdy = (i % 2 == 0);
      out_ready = rdy;
      if (i < 16) begin
        in_start = (i % 8 == 0);
        in_re = W'(256 + 16 * (i / 8) + i % 8);
        in_im = W'(-(256 + 16 * (i / 8) + i % 8));
      end else begin
        in_start = 1'b0;
      end
      pv = out_valid; pre = out_re; pim = out_im; pidx = out_idx;
      tick();
      if (!rdy && pv) begin
        checks++;
        if ({out_valid, out_re, out_im, out_idx} !== {1'b1, pre, pim, pidx}) begin
          errors++;
          $display("FAIL bp_stable[%0d]: got v=%b re=%h idx=%0d want v=1 re=%h idx=%0d",
                   i, out_valid, out_re, out_idx, pre, pidx);
        end
      end
    end
    out_ready = 1'b1;
    tick();
    tick();
    checks++; if (q_re.size() !== qb + 16) begin errors++; $display("FAIL bp_count: got %0d want 16", q_re.size() - qb); end
    for (int j = 0; j < 16 && qb + j < q_re.size(); j++) begin
      logic [W-1:0] er;
      logic [N-1:0] ex;
      er = W'(256 + 16 * (j / 8) + BR[j % 8]);
      ex = N'(j % 8);
      checks++;
      if ({q_re[qb+j], q_idx[qb+j]} !== {er, ex}) begin
        errors++;
        $display("FAIL bp_data[%0d]: got re=%h idx=%0d want re=%h idx=%0d", j, q_re[qb+j], q_idx[qb+j], er, ex);
      end
    end
    checks++; if (ovf_cnt !== ob) begin errors++; $display("FAIL bp_overflow: got %0d pulses want 0", ovf_cnt - ob); end
  endtask

  task automatic test_overflow();
    int qb, ob, ce;
    out_ready = 1'b0;
    qb = q_re.size();
    ob = ovf_cnt;
    send_frame(512, 8, ce);
    send_frame(528, 8, ce);
    in_start = 1'b1;
    in_re = W'(544);
    in_im = W'(-544);
    tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b want 1", overflow); end
    for (int p = 1; p < 8; p++) begin
      in_start = 1'b0;
      in_re = W'(544 + p);
      in_im = W'(-(544 + p));
      tick();
      if (p == 1) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_width: got %b want 0", overflow); end
      end
    end
    repeat (5) tick();
    checks++; if (q_re.size() !== qb) begin errors++; $display("FAIL ovf_stalled: got %0d outputs want 0", q_re.size() - qb); end
    checks++; if (ovf_cnt - ob !== 1) begin errors++; $display("FAIL ovf_count: got %0d pulses want 1", ovf_cnt - ob); end
    out_ready = 1'b1;
    wait_outputs(qb + 16, 100);
    repeat (20) tick();
    checks++; if (q_re.size() !== qb + 16) begin errors++; $display("FAIL ovf_drain_count: got %0d want 16", q_re.size() - qb); end
    for (int j = 0; j < 16 && qb + j < q_re.size(); j++) begin
      logic [W-1:0] er;
      logic [N-1:0] ex;
      er = W'(512 + 16 * (j / 8) + BR[j % 8]);
      ex = N'(j % 8);
      checks++;
      if ({q_re[qb+j], q_idx[qb+j]} !== {er, ex}) begin
        errors++;
        $display("FAIL ovf_data[%0d]: got re=%h idx=%0d want re=%h idx=%0d", j, q_re[qb+j], q_idx[qb+j], er, ex);
      end
    end
  endtask

  task automatic test_abort();
    int qb, ob, ce;
    out_ready = 1'b1;
    qb = q_re.size();
    ob = ovf_cnt;
    send_frame(768, 5, ce);
    send_frame(928, 8, ce);
    wait_outputs(qb + 8, 60);
    repeat (20) tick();
    checks++; if (q_re.size() !== qb + 8) begin errors++; $display("FAIL abort_count: got %0d want 8", q_re.size() - qb); end
    for (int k = 0; k < 8 && qb + k < q_re.size(); k++) begin
      logic [W-1:0] er, ei;
      er = W'(928 + BR[k]);
      ei = W'(-(928 + BR[k]));
      checks++;
      if ({q_re[qb+k], q_im[qb+k], q_idx[qb+k], q_last[qb+k]} !== {er, ei, N'(k), (k == 7)}) begin
        errors++;
        $display("FAIL abort_data[%0d]: got re=%h im=%h idx=%0d want re=%h im=%h idx=%0d",
                 k, q_re[qb+k], q_im[qb+k], q_idx[qb+k], er, ei, k);
      end
    end
    checks++; if (ovf_cnt !== ob) begin errors++; $display("FAIL abort_overflow: got %0d pulses want 0", ovf_cnt - ob); end
  endtask

  task automatic test_reset_mid_drain();
    int qb, ce;
    out_ready = 1'b1;
    send_frame(1024, 8, ce);
    for (int i = 0; i < 40 && !(out_valid === 1'b1 && out_idx === 3'd3); i++) tick();
    checks++;
    if (!(out_valid === 1'b1 && out_idx === 3'd3)) begin
      errors++;
      $display("FAIL rstdrain_reach: got v=%b idx=%0d want v=1 idx=3", out_valid, out_idx);
    end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstdrain_valid: got %b want 0", out_valid); end
    checks++; if (out_idx !== '0) begin errors++; $display("FAIL rstdrain_idx: got %0d want 0", out_idx); end
    tick();
    rst = 1'b0;
    qb = q_re.size();
    repeat (15) tick();
    checks++; if (q_re.size() !== qb) begin errors++; $display("FAIL rstdrain_residual: got %0d outputs want 0", q_re.size() - qb); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstdrain_idle: got %b want 0", out_valid); end
    send_frame(1280, 8, ce);
    wait_outputs(qb + 8, 40);
    tick();
    checks++; if (q_re.size() !== qb + 8) begin errors++; $display("FAIL rstdrain_count: got %0d want 8", q_re.size() - qb); end
    for (int k = 0; k < 8 && qb + k < q_re.size(); k++) begin
      logic [W-1:0] er;
      er = W'(1280 + BR[k]);
      checks++;
      if ({q_re[qb+k], q_idx[qb+k], q_last[qb+k]} !== {er, N'(k), (k == 7)}) begin
        errors++;
        $display("FAIL rstdrain_data[%0d]: got re=%h idx=%0d want re=%h idx=%0d", k, q_re[qb+k], q_idx[qb+k], er, k);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_abort();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
